// File: rtl/sdram_init_seq_pkg.sv
// Shared SDRAM definitions: command encodings, init sequencer states and default mode register fields.
package sdram_init_seq_pkg;

    // Command encodings as {ras_n, cas_n, we_n}
    typedef enum logic [2:0] {
        CMD_LOAD_MODE    = 3'b000,
        CMD_AUTO_REFRESH = 3'b001,
        CMD_PRECHARGE    = 3'b010,
        CMD_ACTIVE       = 3'b011,
        CMD_WRITE        = 3'b100,
        CMD_READ         = 3'b101,
        CMD_BURST_TERM   = 3'b110,
        CMD_NOP          = 3'b111
    } sdram_cmd_e;

    typedef enum logic [3:0] {
        ST_WAIT_LOCK,
        ST_POWERUP,
        ST_PRECHARGE,
        ST_WAIT_RP,
        ST_REFRESH,
        ST_WAIT_RFC,
        ST_LOAD_MODE,
        ST_WAIT_MRD,
        ST_DONE
    } init_state_e;

    localparam int unsigned REF_CNT_W = 4;

    // Mode register: CAS latency 3, sequential bursts, burst length 1
    localparam logic [2:0]  MODE_CL          = 3'd3;
    localparam logic        MODE_BT          = 1'b0;
    localparam logic [2:0]  MODE_BL          = 3'b000;
    localparam logic [11:0] MODE_REG_DEFAULT = {5'b0_0000, MODE_CL, MODE_BT, MODE_BL};

endpackage

// File: rtl/sdram_lock_sync.sv
// Two-flop synchroniser bringing the asynchronous PLL lock indication into the SDRAM clock domain.
module sdram_lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_locked,
    output logic lock_s
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            meta   <= pll_locked;
            lock_s <= meta;
        end
    end

endmodule

// File: rtl/sdram_init_seq.sv
// SDRAM power-up sequencer: waits for PLL lock, then issues NOP wait, PRECHARGE ALL,
// N x AUTO REFRESH and LOAD MODE before handing the bus to the controller.
module sdram_init_seq
    import sdram_init_seq_pkg::*;
#(
    parameter int unsigned POWERUP_CYCLES = 10000,
    parameter int unsigned T_RP_CYCLES    = 2,
    parameter int unsigned T_RFC_CYCLES   = 7,
    parameter int unsigned T_MRD_CYCLES   = 2,
    parameter int unsigned REFRESH_COUNT  = 2,
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter logic [ADDR_WIDTH-1:0] MODE_REG = ADDR_WIDTH'(MODE_REG_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    input  logic                  cmd_ready,
    output logic                  cmd_valid,
    output logic [2:0]            cmd,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [1:0]            ba,
    output logic                  cke,
    output logic                  init_done
);

    localparam int unsigned TIMER_W = $clog2(POWERUP_CYCLES + 1);

    init_state_e            state, state_next;
    logic [TIMER_W-1:0]     timer, timer_next;
    logic [REF_CNT_W-1:0]   ref_cnt, ref_cnt_next;
    logic                   lock_s;
    logic                   accept;
    logic                   timer_zero;

    logic                   cke_next, cmd_valid_next, init_done_next;
    logic [2:0]             cmd_next;
    logic [ADDR_WIDTH-1:0]  addr_next;
    logic [1:0]             ba_next;

    sdram_lock_sync u_lock_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .lock_s     (lock_s)
    );

    assign accept     = cmd_valid & cmd_ready;
    assign timer_zero = (timer == '0);

    // State, shared timer, refresh counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_WAIT_LOCK;
            timer     <= '0;
            ref_cnt   <= '0;
            cke       <= 1'b0;
            cmd_valid <= 1'b0;
            cmd       <= CMD_NOP;
            addr      <= '0;
            ba        <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            ref_cnt   <= ref_cnt_next;
            cke       <= cke_next;
            cmd_valid <= cmd_valid_next;
            cmd       <= cmd_next;
            addr      <= addr_next;
            ba        <= ba_next;
            init_done <= init_done_next;
        end
    end

    // Next state; lock loss overrides everything, including a same-cycle accept
    always_comb begin
        state_next   = state;
        timer_next   = timer;
        ref_cnt_next = ref_cnt;
        if (!lock_s) begin
            state_next   = ST_WAIT_LOCK;
            timer_next   = '0;
            ref_cnt_next = '0;
        end else begin
            case (state)
                ST_WAIT_LOCK: begin
                    state_next = ST_POWERUP;
                    timer_next = TIMER_W'(POWERUP_CYCLES - 1);
                end
                ST_POWERUP: begin
                    if (timer_zero) state_next = ST_PRECHARGE;
                    else            timer_next = timer - TIMER_W'(1);
                end
                ST_PRECHARGE: begin
                    if (accept) begin
                        state_next = ST_WAIT_RP;
                        timer_next = TIMER_W'(T_RP_CYCLES - 1);
                    end
                end
                ST_WAIT_RP: begin
                    if (timer_zero) begin
                        state_next   = ST_REFRESH;
                        ref_cnt_next = '0;
                    end else begin
                        timer_next = timer - TIMER_W'(1);
                    end
                end
                ST_REFRESH: begin
                    if (accept) begin
                        state_next   = ST_WAIT_RFC;
                        timer_next   = TIMER_W'(T_RFC_CYCLES - 1);
                        ref_cnt_next = ref_cnt + REF_CNT_W'(1);
                    end
                end
                ST_WAIT_RFC: begin
                    if (timer_zero) begin
                        state_next = (ref_cnt < REF_CNT_W'(REFRESH_COUNT)) ? ST_REFRESH : ST_LOAD_MODE;
                    end else begin
                        timer_next = timer - TIMER_W'(1);
                    end
                end
                ST_LOAD_MODE: begin
                    if (accept) begin
                        state_next = ST_WAIT_MRD;
                        timer_next = TIMER_W'(T_MRD_CYCLES - 1);
                    end
                end
                ST_WAIT_MRD: begin
                    if (timer_zero) state_next = ST_DONE;
                    else            timer_next = timer - TIMER_W'(1);
                end
                ST_DONE: state_next = ST_DONE;
                default: state_next = ST_WAIT_LOCK;
            endcase
        end
    end

    // Outputs decoded from the next state so the registered values line up with the state
    always_comb begin
        cke_next       = 1'b0;
        cmd_valid_next = 1'b0;
        cmd_next       = CMD_NOP;
        addr_next      = '0;
        ba_next        = '0;
        init_done_next = 1'b0;
        case (state_next)
            ST_WAIT_LOCK: cke_next = 1'b0;
            ST_PRECHARGE: begin
                cke_next       = 1'b1;
                cmd_valid_next = 1'b1;
                cmd_next       = CMD_PRECHARGE;
                addr_next[10]  = 1'b1;
            end
            ST_REFRESH: begin
                cke_next       = 1'b1;
                cmd_valid_next = 1'b1;
                cmd_next       = CMD_AUTO_REFRESH;
            end
            ST_LOAD_MODE: begin
                cke_next       = 1'b1;
                cmd_valid_next = 1'b1;
                cmd_next       = CMD_LOAD_MODE;
                addr_next      = MODE_REG;
            end
            ST_DONE: begin
                cke_next       = 1'b1;
                init_done_next = 1'b1;
            end
            default: cke_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_sdram_init_seq.sv
// Bench for sdram_init_seq: vector table for reset/lock behaviour plus a transaction-level
// schedule model driven with random ready stalls, on 2-refresh and 8-refresh instances.
module tb_sdram_init_seq;

    localparam int P    = 20;
    localparam int TRP  = 2;
    localparam int TRFC = 4;
    localparam int TMRD = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pll_locked = 1'b0;
    logic cmd_ready = 1'b0;

    logic        v0, v1, k0, k1, d0, d1;
    logic [2:0]  c0, c1;
    logic [11:0] a0, a1;
    logic [1:0]  b0, b1;

    logic        o_valid, o_cke, o_done;
    logic [2:0]  o_cmd;
    logic [11:0] o_addr;
    logic [1:0]  o_ba;

    int sel = 0;
    int total = 0;
    int bad = 0;
    int edge_n = 0;

    sdram_init_seq #(
        .POWERUP_CYCLES(P), .T_RP_CYCLES(TRP), .T_RFC_CYCLES(TRFC),
        .T_MRD_CYCLES(TMRD), .REFRESH_COUNT(2), .ADDR_WIDTH(12)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .cmd_ready(cmd_ready),
        .cmd_valid(v0), .cmd(c0), .addr(a0), .ba(b0), .cke(k0), .init_done(d0)
    );

    sdram_init_seq #(
        .POWERUP_CYCLES(P), .T_RP_CYCLES(TRP), .T_RFC_CYCLES(TRFC),
        .T_MRD_CYCLES(TMRD), .REFRESH_COUNT(8), .ADDR_WIDTH(12)
    ) dut8 (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .cmd_ready(cmd_ready),
        .cmd_valid(v1), .cmd(c1), .addr(a1), .ba(b1), .cke(k1), .init_done(d1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    always_comb begin
        if (sel == 1) begin
            o_valid = v1; o_cmd = c1; o_addr = a1; o_ba = b1; o_cke = k1; o_done = d1;
        end else begin
            o_valid = v0; o_cmd = c0; o_addr = a0; o_ba = b0; o_cke = k0; o_done = d0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, dut %0d)", name, act, exp, edge_n, sel);
        end
    endtask

    task automatic reset_and_lock(output int cke_edge);
        @(negedge clk);
        rst_n = 1'b0; pll_locked = 1'b0; cmd_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; pll_locked = 1'b1;
        // two synchroniser edges, then one edge for the registered cke
        cke_edge = edge_n + 3;
    endtask

    // Expected command schedule from the timing rules: each command rises a fixed gap after the
    // previous accept (or after cke rise for PRECHARGE); accept is wherever the bench gives ready.
    task automatic run_seq(input int nref, input int cke_edge, input int pct,
                           input int stall_k, input int stall_len, input int tail);
        logic [2:0]  ecmd[$];
        logic [11:0] eaddr[$];
        int          egap[$];
        int k, rise, done_edge, held, n, ncmd, accepts, iter;
        logic exp_v, r;
        ecmd.push_back(3'b010); eaddr.push_back(12'h400); egap.push_back(TRP);
        for (int i = 0; i < nref; i++) begin
            ecmd.push_back(3'b001); eaddr.push_back(12'h000); egap.push_back(TRFC);
        end
        ecmd.push_back(3'b000); eaddr.push_back(12'h030); egap.push_back(TMRD);
        ncmd = ecmd.size();
        k = 0; rise = cke_edge + P; done_edge = -1; held = 0; accepts = 0; iter = 0;
        while (iter < 3000 && !(done_edge >= 0 && edge_n >= done_edge + tail)) begin
            @(negedge clk);
            iter++;
            n = edge_n;
            exp_v = (k < ncmd) && (n >= rise);
            check("cke", o_cke, n >= cke_edge);
            check("cmd_valid", o_valid, exp_v);
            check("init_done", o_done, done_edge >= 0 && n >= done_edge);
            if (exp_v) begin
                check($sformatf("cmd[%0d]", k), o_cmd, ecmd[k]);
                check($sformatf("addr[%0d]", k), o_addr, eaddr[k]);
                check($sformatf("ba[%0d]", k), o_ba, 0);
            end
            r = int'($urandom_range(99)) < pct;
            if (exp_v && k == stall_k && held < stall_len) r = 1'b0;
            cmd_ready = r;
            if (exp_v) held++;
            if (exp_v && r) begin
                accepts++;
                if (k + 1 < ncmd) rise = n + 1 + egap[k];
                else              done_edge = n + 1 + egap[k];
                k++;
                held = 0;
            end
        end
        check("accepts", accepts, ncmd);
        check("seq_complete", k, ncmd);
    endtask

    typedef struct packed {
        logic        rst_n;
        logic        pll;
        logic        rdy;
        logic [15:0] ncyc;
        logic        cke;
        logic        valid;
        logic        done;
        logic [2:0]  cmd;
        logic [11:0] addr;
    } vec_t;

    initial begin
        vec_t vt[13];
        int ce, found, m;

        // rst_n, pll, ready, cycles to run, then expected cke, valid, done, cmd, addr
        vt[0]  = '{1'b0, 1'b0, 1'b0, 16'd1,  1'b0, 1'b0, 1'b0, 3'b111, 12'h000};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 16'd5,  1'b0, 1'b0, 1'b0, 3'b111, 12'h000};
        vt[2]  = '{1'b1, 1'b1, 1'b0, 16'd2,  1'b0, 1'b0, 1'b0, 3'b111, 12'h000};
        vt[3]  = '{1'b1, 1'b1, 1'b0, 16'd1,  1'b1, 1'b0, 1'b0, 3'b111, 12'h000};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 16'd19, 1'b1, 1'b0, 1'b0, 3'b111, 12'h000};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 16'd1,  1'b1, 1'b1, 1'b0, 3'b010, 12'h400};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 16'd3,  1'b1, 1'b1, 1'b0, 3'b010, 12'h400};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 16'd2,  1'b1, 1'b1, 1'b0, 3'b010, 12'h400};
        vt[8]  = '{1'b1, 1'b0, 1'b1, 16'd1,  1'b0, 1'b0, 1'b0, 3'b111, 12'h000};
        vt[9]  = '{1'b1, 1'b1, 1'b0, 16'd3,  1'b1, 1'b0, 1'b0, 3'b111, 12'h000};
        vt[10] = '{1'b1, 1'b1, 1'b0, 16'd20, 1'b1, 1'b1, 1'b0, 3'b010, 12'h400};
        vt[11] = '{1'b1, 1'b1, 1'b1, 16'd1,  1'b1, 1'b0, 1'b0, 3'b111, 12'h000};
        vt[12] = '{1'b1, 1'b1, 1'b1, 16'd2,  1'b1, 1'b1, 1'b0, 3'b001, 12'h000};

        sel = 0;
        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            rst_n = vt[i].rst_n; pll_locked = vt[i].pll; cmd_ready = vt[i].rdy;
            repeat (int'(vt[i].ncyc)) @(negedge clk);
            check($sformatf("vec%0d_cke", i),   o_cke,   vt[i].cke);
            check($sformatf("vec%0d_valid", i), o_valid, vt[i].valid);
            check($sformatf("vec%0d_done", i),  o_done,  vt[i].done);
            check($sformatf("vec%0d_cmd", i),   o_cmd,   vt[i].cmd);
            check($sformatf("vec%0d_addr", i),  o_addr,  vt[i].addr);
        end

        // nominal sequence with ready always high
        reset_and_lock(ce);
        run_seq(2, ce, 100, -1, 0, 10);

        // first AUTO REFRESH held off for 5 cycles
        reset_and_lock(ce);
        run_seq(2, ce, 100, 1, 5, 5);

        // lock lost in WAIT_RFC after the first refresh, then a full rerun after relock
        reset_and_lock(ce);
        cmd_ready = 1'b1;
        while (edge_n < ce + 24) @(negedge clk);
        check("rfc_wait_valid", o_valid, 0);
        check("rfc_wait_cke", o_cke, 1);
        pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        check("lockloss_cke", o_cke, 0);
        check("lockloss_valid", o_valid, 0);
        check("lockloss_done", o_done, 0);
        check("lockloss_cmd", o_cmd, 3'b111);
        pll_locked = 1'b1;
        m = edge_n;
        run_seq(2, m + 3, 100, -1, 0, 5);

        // random ready stalls
        for (int t = 0; t < 3; t++) begin
            reset_and_lock(ce);
            run_seq(2, ce, 30 + 20 * t, -1, 0, 6);
        end

        // eight refreshes, ready high then random
        sel = 1;
        reset_and_lock(ce);
        run_seq(8, ce, 100, -1, 0, 20);
        reset_and_lock(ce);
        run_seq(8, ce, 60, -1, 0, 10);
        sel = 0;

        // asynchronous reset during a stalled LOAD MODE
        reset_and_lock(ce);
        cmd_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            @(negedge clk);
            if (o_valid && o_cmd == 3'b000) begin
                cmd_ready = 1'b0;
                found = 1;
            end
        end
        check("lmr_reached", found, 1);
        repeat (2) @(negedge clk);
        check("lmr_stall_valid", o_valid, 1);
        check("lmr_stall_addr", o_addr, 12'h030);
        rst_n = 1'b0;
        #1;
        check("async_rst_cke", o_cke, 0);
        check("async_rst_valid", o_valid, 0);
        check("async_rst_cmd", o_cmd, 3'b111);
        check("async_rst_addr", o_addr, 0);
        check("async_rst_ba", o_ba, 0);
        check("async_rst_done", o_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
